// File: rtl/ucode_pkg.sv
// ucode_pkg: shared types and default sizing for the ucode stack-port arbiter
package ucode_pkg;

  localparam int unsigned WBUF_DEPTH = 2;
  localparam int unsigned STARVE_MAX = 4;

  // Source of the read response that is due next cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IU   = 2'd1,
    SRC_UC   = 2'd2,
    SRC_HIT  = 2'd3
  } rd_src_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/ucode_wbuf.sv
// ucode_wbuf: posted ucode write FIFO with a youngest-match word-address lookup
module ucode_wbuf #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = ucode_pkg::WBUF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          one_left_o,
  input  logic [AW-3:0] lkup_word_i,
  output logic          hit_o,
  output logic [DW-1:0] hit_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count;
  logic [PW-1:0] cam_idx;
  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty_o     = (count == '0);
  assign full_o      = (count == CW'(DEPTH));
  assign one_left_o  = (count == CW'(1));
  assign head_addr_o = addr_q[rd_ptr_q[PW-1:0]];
  assign head_data_o = data_q[rd_ptr_q[PW-1:0]];
  assign do_push     = push_i & ~full_o & ~clear_i;
  assign do_pop      = pop_i & ~empty_o & ~clear_i;

  // Pointer update; a clear wins over any push/pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + CW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr_q[PW-1:0]] <= push_addr_i;
      data_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end
  end

  // Scan oldest to youngest so the youngest matching entry supplies the data
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    cam_idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      cam_idx = rd_ptr_q[PW-1:0] + PW'(k);
      if ((CW'(k) < count) && (addr_q[cam_idx][AW-1:2] == lkup_word_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[cam_idx];
      end
    end
  end

endmodule

// File: rtl/ucode_stk_arb.sv
// ucode_stk_arb: schedules the stack-cache port between IU, ucode reads and posted ucode writes
module ucode_stk_arb #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned WBUF_DEPTH = ucode_pkg::WBUF_DEPTH,
  parameter int unsigned STARVE_MAX = ucode_pkg::STARVE_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iu_rd_req,
  input  logic [AW-1:0] iu_rd_addr,
  input  logic          iu_wt_req,
  input  logic [AW-1:0] iu_wt_addr,
  input  logic [DW-1:0] iu_wt_data,
  output logic          iu_gnt,
  input  logic          u_rd_req,
  input  logic [AW-1:0] u_rd_addr,
  output logic          u_rd_gnt,
  output logic          u_rd_vld,
  output logic [DW-1:0] u_rd_data,
  input  logic          u_wt_req,
  input  logic [AW-1:0] u_wt_addr,
  input  logic [DW-1:0] u_wt_data,
  output logic          u_wt_rdy,
  input  logic          u_last,
  output logic          u_drain_busy,
  input  logic          u_abt_rdwt,
  input  logic          ie_kill_ucode,
  output logic          sc_re,
  output logic          sc_we,
  output logic [AW-1:0] sc_addr,
  output logic [DW-1:0] sc_wdata,
  input  logic [DW-1:0] sc_rdata,
  output logic          wbuf_empty
);

  import ucode_pkg::*;

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  state_e        state_q, state_d;
  rd_src_e       rd_src_q, rd_src_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] hit_data_q, hit_data_d;

  logic          wb_full, wb_empty, wb_one_left, wb_hit;
  logic [AW-1:0] wb_head_addr;
  logic [DW-1:0] wb_head_data, wb_hit_data;
  logic          push, pop, uc_port;
  logic          flush_c, iu_req, starved, wb_first, uc_rd_ok, can_drain, nonempty_next;

  assign flush_c       = ie_kill_ucode | u_abt_rdwt;
  assign iu_req        = iu_rd_req | iu_wt_req;
  assign starved       = (starve_q == SW'(STARVE_MAX));
  assign wb_first      = (state_q == ST_DRAIN) | starved;
  assign uc_rd_ok      = u_rd_req & (state_q != ST_DRAIN) & ~flush_c;
  assign can_drain     = ~wb_empty & ~flush_c;
  assign push          = u_wt_req & ~wb_full & ~flush_c & ~reset;
  assign nonempty_next = push | (~wb_empty & ~(pop & wb_one_left));

  assign u_wt_rdy      = ~wb_full;
  assign wbuf_empty    = wb_empty;
  assign u_drain_busy  = (state_q == ST_DRAIN);
  assign u_rd_vld      = ((rd_src_q == SRC_UC) | (rd_src_q == SRC_HIT)) & ~flush_c;

  // Response data: port data only for a ucode miss, registered data for a buffer hit
  always_comb begin
    u_rd_data = '0;
    if (rd_src_q == SRC_UC)       u_rd_data = sc_rdata;
    else if (rd_src_q == SRC_HIT) u_rd_data = hit_data_q;
  end

  ucode_wbuf #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush_c),
    .push_i      (push),
    .push_addr_i (u_wt_addr),
    .push_data_i (u_wt_data),
    .pop_i       (pop),
    .head_addr_o (wb_head_addr),
    .head_data_o (wb_head_data),
    .full_o      (wb_full),
    .empty_o     (wb_empty),
    .one_left_o  (wb_one_left),
    .lkup_word_i (u_rd_addr[AW-1:2]),
    .hit_o       (wb_hit),
    .hit_data_o  (wb_hit_data)
  );

  // Port arbitration, grants and response tagging
  always_comb begin
    iu_gnt     = 1'b0;
    u_rd_gnt   = 1'b0;
    sc_re      = 1'b0;
    sc_we      = 1'b0;
    sc_addr    = '0;
    sc_wdata   = '0;
    pop        = 1'b0;
    uc_port    = 1'b0;
    rd_src_d   = SRC_NONE;
    hit_data_d = hit_data_q;
    if (!reset) begin
      if (wb_first && can_drain)      pop     = 1'b1;
      else if (iu_req)                iu_gnt  = 1'b1;
      else if (uc_rd_ok && !wb_hit)   uc_port = 1'b1;
      else if (can_drain)             pop     = 1'b1;

      if (iu_gnt) begin
        sc_re    = iu_rd_req;
        sc_we    = ~iu_rd_req;
        sc_addr  = iu_rd_req ? iu_rd_addr : iu_wt_addr;
        sc_wdata = iu_rd_req ? '0 : iu_wt_data;
        rd_src_d = iu_rd_req ? SRC_IU : SRC_NONE;
      end else if (uc_port) begin
        sc_re    = 1'b1;
        sc_addr  = u_rd_addr;
        u_rd_gnt = 1'b1;
        rd_src_d = SRC_UC;
      end else if (pop) begin
        sc_we    = 1'b1;
        sc_addr  = wb_head_addr;
        sc_wdata = wb_head_data;
      end

      if (uc_rd_ok && wb_hit) begin
        u_rd_gnt   = 1'b1;
        rd_src_d   = SRC_HIT;
        hit_data_d = wb_hit_data;
      end
    end
  end

  // Starvation counter: counts cycles the buffer waits, cleared by a drain or flush
  always_comb begin
    starve_d = starve_q;
    if (flush_c || pop)              starve_d = '0;
    else if (!wb_empty && !starved)  starve_d = starve_q + SW'(1);
  end

  // Phase FSM next state; kill/abort overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (u_last && nonempty_next) state_d = ST_DRAIN;
      ST_DRAIN: if (!nonempty_next)          state_d = ST_RUN;
      ST_FLUSH:                              state_d = ST_RUN;
      default:                               state_d = ST_RUN;
    endcase
    if (flush_c) state_d = ST_FLUSH;
  end

  // State, counter and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      rd_src_q   <= SRC_NONE;
      starve_q   <= '0;
      hit_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_src_q   <= rd_src_d;
      starve_q   <= starve_d;
      hit_data_q <= hit_data_d;
    end
  end

endmodule

// File: tb/tb_ucode_stk_arb.sv
// tb_ucode_stk_arb: directed checks of the ucode stack-port arbiter
module tb_ucode_stk_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        iu_rd_req, iu_wt_req, iu_gnt;
  logic [31:0] iu_rd_addr, iu_wt_addr, iu_wt_data;
  logic        u_rd_req, u_rd_gnt, u_rd_vld;
  logic [31:0] u_rd_addr, u_rd_data;
  logic        u_wt_req, u_wt_rdy;
  logic [31:0] u_wt_addr, u_wt_data;
  logic        u_last, u_drain_busy, u_abt_rdwt, ie_kill_ucode;
  logic        sc_re, sc_we, wbuf_empty;
  logic [31:0] sc_addr, sc_wdata;
  logic [31:0] sc_rdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stack-cache model: read data returned the cycle after sc_re
  always @(posedge clk) if (sc_re) sc_rdata <= sc_addr ^ 32'h5A5A_0000;

  ucode_stk_arb dut (
    .clk           (clk),
    .reset         (reset),
    .iu_rd_req     (iu_rd_req),
    .iu_rd_addr    (iu_rd_addr),
    .iu_wt_req     (iu_wt_req),
    .iu_wt_addr    (iu_wt_addr),
    .iu_wt_data    (iu_wt_data),
    .iu_gnt        (iu_gnt),
    .u_rd_req      (u_rd_req),
    .u_rd_addr     (u_rd_addr),
    .u_rd_gnt      (u_rd_gnt),
    .u_rd_vld      (u_rd_vld),
    .u_rd_data     (u_rd_data),
    .u_wt_req      (u_wt_req),
    .u_wt_addr     (u_wt_addr),
    .u_wt_data     (u_wt_data),
    .u_wt_rdy      (u_wt_rdy),
    .u_last        (u_last),
    .u_drain_busy  (u_drain_busy),
    .u_abt_rdwt    (u_abt_rdwt),
    .ie_kill_ucode (ie_kill_ucode),
    .sc_re         (sc_re),
    .sc_we         (sc_we),
    .sc_addr       (sc_addr),
    .sc_wdata      (sc_wdata),
    .sc_rdata      (sc_rdata),
    .wbuf_empty    (wbuf_empty)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iu_rd_req = 0; iu_rd_addr = 0; iu_wt_req = 0; iu_wt_addr = 0; iu_wt_data = 0;
    u_rd_req = 0; u_rd_addr = 0; u_wt_req = 0; u_wt_addr = 0; u_wt_data = 0;
    u_last = 0; u_abt_rdwt = 0; ie_kill_ucode = 0;
  endtask

  // Reset values during and after reset; {re,we,iu_gnt,rd_gnt,vld,busy,rdy,empty}
  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sc_re, sc_we, iu_gnt, u_rd_gnt, u_rd_vld, u_drain_busy, u_wt_rdy, wbuf_empty} !== 8'b0000_0011) begin
      failures++;
      $display("FAIL reset_in got=%b exp=%b", {sc_re, sc_we, iu_gnt, u_rd_gnt, u_rd_vld, u_drain_busy, u_wt_rdy, wbuf_empty}, 8'b0000_0011);
    end
    cyc(); reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({sc_re, sc_we, iu_gnt, u_rd_gnt, u_rd_vld, u_drain_busy, u_wt_rdy, wbuf_empty} !== 8'b0000_0011) begin
      failures++;
      $display("FAIL reset_out got=%b exp=%b", {sc_re, sc_we, iu_gnt, u_rd_gnt, u_rd_vld, u_drain_busy, u_wt_rdy, wbuf_empty}, 8'b0000_0011);
    end
  endtask

  // Buffer hit forwarding, including the youngest of two matching entries
  task automatic test_rd_hit();
    cyc(); u_wt_req = 1; u_wt_addr = 32'h100; u_wt_data = 32'hA5;
    @(negedge clk);
    checks++;
    if ({u_wt_rdy, sc_re, sc_we} !== 3'b100) begin
      failures++; $display("FAIL hit_push got=%b exp=%b", {u_wt_rdy, sc_re, sc_we}, 3'b100);
    end
    cyc(); u_wt_req = 0; u_rd_req = 1; u_rd_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({u_rd_gnt, sc_re} !== 2'b10) begin
      failures++; $display("FAIL hit_gnt got=%b exp=%b", {u_rd_gnt, sc_re}, 2'b10);
    end
    checks++;
    if ({sc_we, sc_addr, sc_wdata} !== {1'b1, 32'h100, 32'hA5}) begin
      failures++; $display("FAIL hit_drain got=%b/%h/%h exp=1/100/a5", sc_we, sc_addr, sc_wdata);
    end
    cyc(); u_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({u_rd_vld, u_rd_data} !== {1'b1, 32'hA5}) begin
      failures++; $display("FAIL hit_data got=%b/%h exp=1/a5", u_rd_vld, u_rd_data);
    end
    cyc(); iu_rd_req = 1; iu_rd_addr = 32'h800; u_wt_req = 1; u_wt_addr = 32'h104; u_wt_data = 32'h11;
    cyc(); u_wt_data = 32'h22;
    cyc(); u_wt_req = 0; u_rd_req = 1; u_rd_addr = 32'h106;
    @(negedge clk);
    checks++;
    if ({u_rd_gnt, iu_gnt, sc_re, sc_addr} !== {3'b111, 32'h800}) begin
      failures++; $display("FAIL hit_young_gnt got=%b%b%b/%h exp=111/800", u_rd_gnt, iu_gnt, sc_re, sc_addr);
    end
    cyc(); u_rd_req = 0; iu_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({u_rd_vld, u_rd_data} !== {1'b1, 32'h22}) begin
      failures++; $display("FAIL hit_young_data got=%b/%h exp=1/22", u_rd_vld, u_rd_data);
    end
    checks++;
    if ({sc_we, sc_wdata} !== {1'b1, 32'h11}) begin
      failures++; $display("FAIL hit_drain_old got=%b/%h exp=1/11", sc_we, sc_wdata);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({sc_we, sc_wdata} !== {1'b1, 32'h22}) begin
      failures++; $display("FAIL hit_drain_young got=%b/%h exp=1/22", sc_we, sc_wdata);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({wbuf_empty, sc_we} !== 2'b10) begin
      failures++; $display("FAIL hit_empty got=%b exp=%b", {wbuf_empty, sc_we}, 2'b10);
    end
  endtask

  // Read miss through the port, and IU beating a ucode read
  task automatic test_rd_miss();
    cyc(); u_rd_req = 1; u_rd_addr = 32'h200;
    @(negedge clk);
    checks++;
    if ({u_rd_gnt, sc_re, sc_we, sc_addr} !== {3'b110, 32'h200}) begin
      failures++; $display("FAIL miss_gnt got=%b%b%b/%h exp=110/200", u_rd_gnt, sc_re, sc_we, sc_addr);
    end
    cyc(); u_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({u_rd_vld, u_rd_data} !== {1'b1, 32'h5A5A_0200}) begin
      failures++; $display("FAIL miss_data got=%b/%h exp=1/5a5a0200", u_rd_vld, u_rd_data);
    end
    cyc(); iu_wt_req = 1; iu_wt_addr = 32'h300; iu_wt_data = 32'h77; u_rd_req = 1; u_rd_addr = 32'h204;
    @(negedge clk);
    checks++;
    if ({iu_gnt, u_rd_gnt, sc_we, sc_addr, sc_wdata} !== {3'b101, 32'h300, 32'h77}) begin
      failures++; $display("FAIL miss_iu_wins got=%b%b%b/%h/%h exp=101/300/77", iu_gnt, u_rd_gnt, sc_we, sc_addr, sc_wdata);
    end
    cyc(); iu_wt_req = 0;
    @(negedge clk);
    checks++;
    if ({u_rd_gnt, u_rd_vld, sc_re} !== 3'b101) begin
      failures++; $display("FAIL miss_after_iu got=%b exp=%b", {u_rd_gnt, u_rd_vld, sc_re}, 3'b101);
    end
    cyc(); u_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({u_rd_vld, u_rd_data} !== {1'b1, 32'h5A5A_0204}) begin
      failures++; $display("FAIL miss_data2 got=%b/%h exp=1/5a5a0204", u_rd_vld, u_rd_data);
    end
  endtask

  // One entry waits behind a steady IU read stream until the counter saturates
  task automatic test_starve();
    logic [1:0] exp;
    cyc(); u_wt_req = 1; u_wt_addr = 32'h180; u_wt_data = 32'h33;
    for (int i = 1; i <= 6; i++) begin
      cyc(); u_wt_req = 0; iu_rd_req = 1; iu_rd_addr = 32'h900;
      exp = (i == 5) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if ({iu_gnt, sc_we} !== exp) begin
        failures++; $display("FAIL starve_c%0d got=%b exp=%b", i, {iu_gnt, sc_we}, exp);
      end
    end
    cyc(); iu_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({wbuf_empty, sc_we} !== 2'b10) begin
      failures++; $display("FAIL starve_empty got=%b exp=%b", {wbuf_empty, sc_we}, 2'b10);
    end
  endtask

  // Full buffer refuses a write until a pop frees a slot
  task automatic test_full();
    cyc(); iu_rd_req = 1; u_wt_req = 1; u_wt_addr = 32'h10; u_wt_data = 32'h1;
    cyc(); u_wt_addr = 32'h14; u_wt_data = 32'h2;
    cyc(); u_wt_addr = 32'h18; u_wt_data = 32'h3;
    @(negedge clk);
    checks++;
    if ({u_wt_rdy, wbuf_empty} !== 2'b00) begin
      failures++; $display("FAIL full_rdy got=%b exp=%b", {u_wt_rdy, wbuf_empty}, 2'b00);
    end
    cyc(); iu_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({u_wt_rdy, sc_we, sc_addr} !== {2'b01, 32'h10}) begin
      failures++; $display("FAIL full_pop got=%b%b/%h exp=01/10", u_wt_rdy, sc_we, sc_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({u_wt_rdy, sc_we, sc_addr} !== {2'b11, 32'h14}) begin
      failures++; $display("FAIL full_accept got=%b%b/%h exp=11/14", u_wt_rdy, sc_we, sc_addr);
    end
    cyc(); u_wt_req = 0;
    @(negedge clk);
    checks++;
    if ({sc_we, sc_addr, sc_wdata} !== {1'b1, 32'h18, 32'h3}) begin
      failures++; $display("FAIL full_third got=%b/%h/%h exp=1/18/3", sc_we, sc_addr, sc_wdata);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({wbuf_empty, sc_we} !== 2'b10) begin
      failures++; $display("FAIL full_once got=%b exp=%b", {wbuf_empty, sc_we}, 2'b10);
    end
  endtask

  // Two entries drained on u_last ahead of the IU, ucode reads refused meanwhile
  task automatic test_drain();
    cyc(); iu_rd_req = 1; iu_rd_addr = 32'h900; u_wt_req = 1; u_wt_addr = 32'h20; u_wt_data = 32'hB1;
    cyc(); u_wt_addr = 32'h24; u_wt_data = 32'hB2;
    cyc(); u_wt_req = 0; u_last = 1;
    @(negedge clk);
    checks++;
    if ({u_drain_busy, iu_gnt} !== 2'b01) begin
      failures++; $display("FAIL drain_last got=%b exp=%b", {u_drain_busy, iu_gnt}, 2'b01);
    end
    cyc(); u_last = 0; u_rd_req = 1; u_rd_addr = 32'h24;
    @(negedge clk);
    checks++;
    if ({u_drain_busy, sc_we, iu_gnt, u_rd_gnt, sc_addr, sc_wdata} !== {4'b1100, 32'h20, 32'hB1}) begin
      failures++; $display("FAIL drain_first got=%b%b%b%b/%h/%h exp=1100/20/b1", u_drain_busy, sc_we, iu_gnt, u_rd_gnt, sc_addr, sc_wdata);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({u_drain_busy, sc_we, iu_gnt, u_rd_gnt, u_rd_vld, sc_addr, sc_wdata} !== {5'b11000, 32'h24, 32'hB2}) begin
      failures++; $display("FAIL drain_second got=%b%b%b%b%b/%h/%h exp=11000/24/b2", u_drain_busy, sc_we, iu_gnt, u_rd_gnt, u_rd_vld, sc_addr, sc_wdata);
    end
    cyc(); u_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({u_drain_busy, iu_gnt, wbuf_empty, u_rd_vld} !== 4'b0110) begin
      failures++; $display("FAIL drain_run got=%b exp=%b", {u_drain_busy, iu_gnt, wbuf_empty, u_rd_vld}, 4'b0110);
    end
    cyc(); iu_rd_req = 0;
  endtask

  // Asynchronous reset while draining two entries
  task automatic test_reset_mid_drain();
    cyc(); iu_rd_req = 1; u_wt_req = 1; u_wt_addr = 32'h40; u_wt_data = 32'hC1;
    cyc(); u_wt_addr = 32'h44; u_wt_data = 32'hC2;
    cyc(); u_wt_req = 0; u_last = 1;
    cyc(); u_last = 0;
    @(negedge clk);
    checks++;
    if ({u_drain_busy, sc_we} !== 2'b11) begin
      failures++; $display("FAIL rstd_pre got=%b exp=%b", {u_drain_busy, sc_we}, 2'b11);
    end
    reset = 1'b1; iu_rd_req = 0;
    cyc(); reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({wbuf_empty, u_drain_busy, sc_we} !== 3'b100) begin
      failures++; $display("FAIL rstd_post got=%b exp=%b", {wbuf_empty, u_drain_busy, sc_we}, 3'b100);
    end
  endtask

  // Kill with a posted write, an entry pending, u_last, and a UC read outstanding
  task automatic test_kill();
    cyc(); iu_rd_req = 1; u_wt_req = 1; u_wt_addr = 32'h500; u_wt_data = 32'hDD;
    cyc(); iu_rd_req = 0; u_wt_req = 0; u_rd_req = 1; u_rd_addr = 32'h300;
    @(negedge clk);
    checks++;
    if ({u_rd_gnt, sc_re, sc_we} !== 3'b110) begin
      failures++; $display("FAIL kill_rd got=%b exp=%b", {u_rd_gnt, sc_re, sc_we}, 3'b110);
    end
    cyc(); u_rd_req = 0; ie_kill_ucode = 1; u_last = 1; u_wt_req = 1; u_wt_addr = 32'h400; u_wt_data = 32'hCC;
    @(negedge clk);
    checks++;
    if ({u_rd_vld, sc_we, sc_re} !== 3'b000) begin
      failures++; $display("FAIL kill_squash got=%b exp=%b", {u_rd_vld, sc_we, sc_re}, 3'b000);
    end
    cyc(); ie_kill_ucode = 0; u_last = 0; u_wt_req = 0;
    @(negedge clk);
    checks++;
    if ({wbuf_empty, u_drain_busy, sc_we, u_rd_vld} !== 4'b1000) begin
      failures++; $display("FAIL kill_flush got=%b exp=%b", {wbuf_empty, u_drain_busy, sc_we, u_rd_vld}, 4'b1000);
    end
    cyc(); u_abt_rdwt = 0; u_rd_req = 1; u_rd_addr = 32'h304;
    @(negedge clk);
    checks++;
    if ({u_rd_gnt, sc_re, u_drain_busy, wbuf_empty} !== 4'b1101) begin
      failures++; $display("FAIL kill_run got=%b exp=%b", {u_rd_gnt, sc_re, u_drain_busy, wbuf_empty}, 4'b1101);
    end
    cyc(); u_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({u_rd_vld, u_rd_data} !== {1'b1, 32'h5A5A_0304}) begin
      failures++; $display("FAIL kill_after got=%b/%h exp=1/5a5a0304", u_rd_vld, u_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_rd_hit();
    test_rd_miss();
    test_starve();
    test_full();
    test_drain();
    test_reset_mid_drain();
    test_kill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
